// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of dp_mem port B between core (req 0) and debug master (req 1).
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_i,
  input  logic [2*ADDR_W-1:0]       addr_i,
  input  logic [2*(DATA_W/8)-1:0]   wsel_byte_i,
  input  logic [2*DATA_W-1:0]       wdata_i,
  output logic [1:0]                gnt_o,
  output logic [1:0]                rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      mem_en_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W/8-1:0]       mem_wsel_byte_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]               stat_gnt0_o,
  output logic [31:0]               stat_gnt1_o,
  output logic [31:0]               stat_conflict_o
`endif
);
  localparam int BW = DATA_W / 8;
  logic          r_prio;
  logic          r_rpend;
  logic          r_rtag;
  logic          w_sel;
  logic [BW-1:0] w_wsel;
  // r_prio names the requester that wins the next conflict
  always_comb begin
    gnt_o[0]        = ~rst_i & req_i[0] & (~req_i[1] | ~r_prio);
    gnt_o[1]        = ~rst_i & req_i[1] & (~req_i[0] | r_prio);
    w_sel           = gnt_o[1];
    w_wsel          = w_sel ? wsel_byte_i[BW+:BW] : wsel_byte_i[0+:BW];
    mem_en_o        = |gnt_o;
    mem_addr_o      = w_sel ? addr_i[ADDR_W+:ADDR_W] : addr_i[0+:ADDR_W];
    mem_wdata_o     = w_sel ? wdata_i[DATA_W+:DATA_W] : wdata_i[0+:DATA_W];
    mem_wsel_byte_o = mem_en_o ? w_wsel : '0;
    rvalid_o        = (r_rpend & ~rst_i) ? {r_rtag, ~r_rtag} : 2'b00;
    rdata_o         = mem_rdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio  <= 1'b0;
      r_rpend <= 1'b0;
      r_rtag  <= 1'b0;
    end else begin
      if (mem_en_o) r_prio <= gnt_o[0];
      r_rpend <= mem_en_o & ~|w_wsel;
      r_rtag  <= w_sel;
    end
  end
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_gnt0;
  logic [31:0] r_stat_gnt1;
  logic [31:0] r_stat_conflict;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_gnt0     <= '0;
      r_stat_gnt1     <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (gnt_o[0] && ~&r_stat_gnt0) r_stat_gnt0 <= r_stat_gnt0 + 32'd1;
      if (gnt_o[1] && ~&r_stat_gnt1) r_stat_gnt1 <= r_stat_gnt1 + 32'd1;
      if (&req_i && ~&r_stat_conflict) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end
  assign stat_gnt0_o     = r_stat_gnt0;
  assign stat_gnt1_o     = r_stat_gnt1;
  assign stat_conflict_o = r_stat_conflict;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table, directed corner sequences and constrained-random traffic
// against a last-winner/scoreboard reference model with a behavioural memory behind port B.
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0]      req_i;
  logic [2*AW-1:0] addr_i;
  logic [2*BW-1:0] wsel_byte_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o, mem_wdata_o, mem_rdata_i;
  logic            mem_en_o;
  logic [AW-1:0]   mem_addr_o;
  logic [BW-1:0]   mem_wsel_byte_o;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]     stat_gnt0_o, stat_gnt1_o, stat_conflict_o;
`endif

  logic [31:0] a[2];
  logic [3:0]  ws[2];
  logic [31:0] wd[2];
  assign addr_i      = {a[1], a[0]};
  assign wsel_byte_i = {ws[1], ws[0]};
  assign wdata_i     = {wd[1], wd[0]};

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
    .wsel_byte_i(wsel_byte_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_wsel_byte_o(mem_wsel_byte_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0_o(stat_gnt0_o), .stat_gnt1_o(stat_gnt1_o), .stat_conflict_o(stat_conflict_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h0101_0103) ^ 32'hA5A5_0000;
  endfunction

  // memory behind port B: 1-cycle read latency, byte-enabled writes
  logic [31:0] env_mem[256];
  always @(posedge clk_i)
    if (mem_en_o) begin
      if (mem_wsel_byte_o == 4'h0) mem_rdata_i <= env_mem[mem_addr_o[9:2]];
      else for (int b = 0; b < 4; b++)
        if (mem_wsel_byte_o[b]) env_mem[mem_addr_o[9:2]][8*b+:8] <= mem_wdata_o[8*b+:8];
    end

  // reference model: memory image, who won last, and the response due next cycle
  logic [31:0] ref_mem[256];
  bit          last_win;
  logic [1:0]  exp_rv;
  logic [31:0] exp_rd;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick(output logic [1:0] og, output logic [1:0] orv, output logic [31:0] ord);
    logic [1:0] r, g;
    int k, i;
    @(negedge clk_i);
    r = rst_i ? 2'b00 : req_i;
    g = (r == 2'b11) ? (last_win ? 2'b01 : 2'b10) : r;
    k = g[1] ? 1 : 0;
    og = gnt_o; orv = rvalid_o; ord = rdata_o;
    chk("gnt", gnt_o, g);
    chk("mem_en", mem_en_o, |g);
    if (g == 2'b00) chk("wsel_idle", mem_wsel_byte_o, 0);
    else begin
      chk("mem_addr", mem_addr_o, a[k]);
      chk("mem_wsel", mem_wsel_byte_o, ws[k]);
      if (ws[k] != 4'h0) chk("mem_wdata", mem_wdata_o, wd[k]);
    end
    chk("rvalid", rvalid_o, rst_i ? 2'b00 : exp_rv);
    if (!rst_i && exp_rv != 2'b00) chk("rdata", rdata_o, exp_rd);
    @(posedge clk_i);
    exp_rv = 2'b00;
    if (rst_i) last_win = 1'b1;
    else if (g != 2'b00) begin
      last_win = (k == 1);
      i = int'(a[k][9:2]);
      if (ws[k] == 4'h0) begin
        exp_rv = g;
        exp_rd = ref_mem[i];
      end else for (int b = 0; b < 4; b++)
        if (ws[k][b]) ref_mem[i][8*b+:8] = wd[k][8*b+:8];
    end
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] ws0, ws1;
    logic [1:0] gnt, rv;
  } vec_t;
  vec_t tbl[14];

  logic [1:0]  og, orv;
  logic [31:0] ord;
  bit          pend[2];

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 4'h0, 4'h0, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 2'b11, 4'h0, 4'h0, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 2'b11, 4'h0, 4'h0, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 2'b11, 4'h0, 4'h0, 2'b01, 2'b00};
    tbl[4]  = '{1'b0, 2'b11, 4'h0, 4'h0, 2'b10, 2'b01};
    tbl[5]  = '{1'b0, 2'b11, 4'h0, 4'h0, 2'b01, 2'b10};
    tbl[6]  = '{1'b0, 2'b11, 4'h0, 4'h0, 2'b10, 2'b01};
    tbl[7]  = '{1'b0, 2'b11, 4'h0, 4'h0, 2'b01, 2'b10};
    tbl[8]  = '{1'b0, 2'b11, 4'h0, 4'h0, 2'b10, 2'b01};
    tbl[9]  = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 2'b10};
    tbl[10] = '{1'b0, 2'b01, 4'h0, 4'h0, 2'b01, 2'b00};
    tbl[11] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 2'b01};
    tbl[12] = '{1'b0, 2'b10, 4'h0, 4'hF, 2'b10, 2'b00};
    tbl[13] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00};
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    last_win = 1'b1;
    exp_rv = 2'b00;
    exp_rd = '0;
    rst_i = 1'b1;
    req_i = 2'b00;
    a[0] = 32'h8000_0010; a[1] = 32'h8000_0020;
    wd[0] = 32'h0; wd[1] = 32'h5555_AAAA;
    ws[0] = 4'h0; ws[1] = 4'h0;
    for (int i = 0; i < 14; i++) begin
      rst_i = tbl[i].rst; req_i = tbl[i].req; ws[0] = tbl[i].ws0; ws[1] = tbl[i].ws1;
      tick(og, orv, ord);
      chk($sformatf("vec%0d_gnt", i), og, tbl[i].gnt);
      chk($sformatf("vec%0d_rv", i), orv, tbl[i].rv);
      if (i == 11) chk("single_read_data", ord, init_word(4));
    end
    // write then read by debug master
    a[1] = 32'h8000_0100; ws[1] = 4'hF; wd[1] = 32'hDEAD_BEEF; req_i = 2'b10;
    tick(og, orv, ord);
    ws[1] = 4'h0;
    tick(og, orv, ord);
    req_i = 2'b00;
    tick(og, orv, ord);
    chk("wr_rd_rv", orv, 2'b10);
    chk("wr_rd_data", ord, 32'hDEAD_BEEF);
    // partial write by core
    a[0] = 32'h8000_0200; ws[0] = 4'hF; wd[0] = 32'h1122_3344; req_i = 2'b01;
    tick(og, orv, ord);
    ws[0] = 4'b0010; wd[0] = 32'h0000_AB00;
    tick(og, orv, ord);
    chk("partial_wr_rv", orv, 2'b00);
    ws[0] = 4'h0;
    tick(og, orv, ord);
    chk("partial_wr_rv2", orv, 2'b00);
    req_i = 2'b00;
    tick(og, orv, ord);
    chk("partial_rd_data", ord, 32'h1122_AB44);
    // reset lands on the cycle a core read would return
    req_i = 2'b01;
    tick(og, orv, ord);
    rst_i = 1'b1; req_i = 2'b00;
    tick(og, orv, ord);
    chk("rst_mid_rv", orv, 2'b00);
    rst_i = 1'b0;
    tick(og, orv, ord);
    chk("rst_after_rv", orv, 2'b00);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_gnt0_clr", stat_gnt0_o, 0);
    chk("stat_gnt1_clr", stat_gnt1_o, 0);
    chk("stat_conf_clr", stat_conflict_o, 0);
`endif
    req_i = 2'b11; a[1] = 32'h8000_0040;
    tick(og, orv, ord);
    chk("rst_prio_core", og, 2'b01);
    req_i = 2'b00;
    tick(og, orv, ord);
    // random traffic; each requester holds its request until granted
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && $urandom_range(1) == 1) begin
          pend[k] = 1'b1;
          a[k] = 32'h8000_0000 | (32'($urandom_range(63)) << 2);
          ws[k] = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
          wd[k] = $urandom;
        end
      req_i = {pend[1], pend[0]};
      tick(og, orv, ord);
      if (og[0]) pend[0] = 1'b0;
      if (og[1]) pend[1] = 1'b0;
    end
    req_i = 2'b00;
    tick(og, orv, ord);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
